// File: rtl/evolution_scheduler_if.sv
// Bundle of the control, source-read, destination-write and update-unit
// signals that connect the evolution scheduler to its environment.
// master: the scheduler. slave: memories, update unit and controller.
interface evolution_scheduler_if #(
    parameter int BLOCK_LEN = 16,
    parameter int ADDR_W    = 10
);
    // Generation control
    logic                   start;
    logic                   busy;
    logic                   done;

    // Source board memory (read-only, 1-cycle latency)
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [BLOCK_LEN-1:0]   rd_data;

    // Destination board memory (write-only)
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [BLOCK_LEN-1:0]   wr_data;

    // Combinational generation-update unit
    logic [3*BLOCK_LEN-1:0] last_line_status;
    logic [3*BLOCK_LEN-1:0] line_status;
    logic [BLOCK_LEN-1:0]   now_live;
    logic                   prev_live_single;

    modport master (
        input  start, rd_data, now_live, prev_live_single,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data,
               last_line_status, line_status
    );

    modport slave (
        output start, rd_data, now_live, prev_live_single,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data,
               last_line_status, line_status
    );
endinterface

// File: rtl/evolution_scheduler.sv
// Game-of-Life generation sequencer. Walks the board row by row and block
// by block, assembles three-row windows for the combinational update unit,
// and writes each block of the next generation one step late so that the
// update unit's corrected last cell (prev_live_single) can be stitched in.
module evolution_scheduler #(
    parameter int BLOCK_LEN = 16,
    parameter int W_BLOCKS  = 7,
    parameter int H         = 100,
    parameter int ADDR_W    = $clog2(H*W_BLOCKS)
) (
    input  logic clk,
    input  logic rst,
    evolution_scheduler_if.master bus
);
    localparam int ROW_W  = (H > 1) ? $clog2(H) : 1;
    localparam int STEP_W = $clog2(W_BLOCKS + 1);
    localparam int WIN_W  = 3*BLOCK_LEN;

    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(H - 1);
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(W_BLOCKS - 1);
    localparam logic [STEP_W-1:0] FLUSH_STEP = STEP_W'(W_BLOCKS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        FETCH1,
        FETCH2,
        CAPT,
        EVAL,
        DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [ROW_W-1:0]      row_reg, row_next;
    logic [STEP_W-1:0]     step_reg, step_next;
    logic                  rd_pending_reg;       // a read was issued last cycle
    logic [WIN_W-1:0]      last_win_reg;         // window of the previous step
    logic [BLOCK_LEN-2:0]  held_reg;             // resolved cells of the previous block
    logic [WIN_W-1:0]      win;                  // window being assembled
    logic [2:0]            cap_sel;
    logic [1:0]            fetch_k;
    logic                  fetch_state;
    logic                  row_ok;
    logic                  is_flush;
    logic                  rd_en;
    logic                  wr_en;
    logic [ROW_W:0]        rd_row;
    logic [ADDR_W-1:0]     rd_addr_calc;
    logic [ADDR_W-1:0]     wr_addr_calc;

    // The flush step only exists in EVAL; fetch states always have step < W_BLOCKS.
    assign is_flush    = (step_reg == FLUSH_STEP);
    assign fetch_state = (state_reg inside {FETCH0, FETCH1, FETCH2});

    // Which of the three window rows the current fetch state addresses
    always_comb begin
        fetch_k = 2'd0;
        case (state_reg)
            FETCH1:  fetch_k = 2'd1;
            FETCH2:  fetch_k = 2'd2;
            default: fetch_k = 2'd0;
        endcase
    end

    // Row r-1 is off the board on row 0, row r+1 is off the board on the last row.
    assign row_ok = !((fetch_k == 2'd0) && (row_reg == '0)) &&
                    !((fetch_k == 2'd2) && (row_reg == LAST_ROW));
    assign rd_row = {1'b0, row_reg} + (ROW_W+1)'(fetch_k) - (ROW_W+1)'(1);

    assign rd_addr_calc = ADDR_W'(rd_row) * ADDR_W'(W_BLOCKS) + ADDR_W'(step_reg);
    assign wr_addr_calc = ADDR_W'(row_reg) * ADDR_W'(W_BLOCKS) + ADDR_W'(step_reg)
                          - ADDR_W'(1);

    assign rd_en = fetch_state && row_ok;
    assign wr_en = (state_reg == EVAL) && (step_reg != '0);

    // Data for window row k arrives one state after its fetch: FETCH1, FETCH2, CAPT.
    assign cap_sel = {state_reg == CAPT, state_reg == FETCH2, state_reg == FETCH1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            logic [BLOCK_LEN-1:0] slot_reg;

            // Capture the returned word for window row gi, or zero for an off-board row
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (cap_sel[gi]) begin
                    slot_reg <= rd_pending_reg ? bus.rd_data : '0;
                end
            end

            assign win[gi*BLOCK_LEN +: BLOCK_LEN] = slot_reg;
        end
    endgenerate

    // Next-state logic: five-cycle block steps, then a one-cycle flush per row
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        step_next  = step_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = FETCH0;
                    row_next   = '0;
                    step_next  = '0;
                end
            end
            FETCH0: state_next = FETCH1;
            FETCH1: state_next = FETCH2;
            FETCH2: state_next = CAPT;
            CAPT:   state_next = EVAL;
            EVAL: begin
                if (is_flush) begin
                    step_next = '0;
                    if (row_reg == LAST_ROW) begin
                        state_next = DONE;
                    end else begin
                        row_next   = row_reg + ROW_W'(1);
                        state_next = FETCH0;
                    end
                end else begin
                    step_next  = step_reg + STEP_W'(1);
                    state_next = (step_reg == LAST_STEP) ? EVAL : FETCH0;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, position counters and read-pending flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            step_reg       <= '0;
            rd_pending_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            step_reg       <= step_next;
            rd_pending_reg <= rd_en;
        end
    end

    // On EVAL remember this step's window and resolved cells for the next step;
    // the flush step leaves a zero window so the next row starts with no left context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_win_reg <= '0;
            held_reg     <= '0;
        end else if (state_reg == EVAL) begin
            last_win_reg <= is_flush ? '0 : win;
            held_reg     <= bus.now_live[BLOCK_LEN-2:0];
        end else if ((state_reg == IDLE) && bus.start) begin
            last_win_reg <= '0;
        end
    end

    assign bus.busy             = (state_reg != IDLE) && (state_reg != DONE);
    assign bus.done             = (state_reg == DONE);
    assign bus.rd_en            = rd_en;
    assign bus.rd_addr          = rd_en ? rd_addr_calc : '0;
    assign bus.wr_en            = wr_en;
    assign bus.wr_addr          = wr_en ? wr_addr_calc : '0;
    assign bus.wr_data          = wr_en ? {bus.prev_live_single, held_reg} : '0;
    assign bus.line_status      = is_flush ? '0 : win;
    assign bus.last_line_status = last_win_reg;
endmodule

// File: tb/tb_evolution_scheduler.sv
// Bench for evolution_scheduler on a 4-row, 2-block, 4-cell-per-block board.
// Provides a source memory, a behavioural update unit and a whole-board
// Game-of-Life reference; checks the DUT every cycle against the schedule.
module tb_evolution_scheduler;
    localparam int BL   = 4;
    localparam int WB   = 2;
    localparam int HH   = 4;
    localparam int AW   = $clog2(HH*WB);
    localparam int N    = HH*(5*WB + 1);
    localparam int COLS = BL*WB;
    localparam int NW   = HH*WB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Cycle counter used to place every comparison relative to the start edge
    always @(posedge clk) cyc <= cyc + 1;

    evolution_scheduler_if #(.BLOCK_LEN(BL), .ADDR_W(AW)) bus ();

    evolution_scheduler #(
        .BLOCK_LEN(BL),
        .W_BLOCKS (WB),
        .H        (HH),
        .ADDR_W   (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic          board [HH][COLS];
    logic          nxt   [HH][COLS];
    logic [BL-1:0] src_mem [NW];
    logic [BL-1:0] dst_mem [NW];

    int  base = 0;
    bit  active = 0;
    int  wr_count, done_count, busy_count, done_o;

    // Source memory: one-cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= src_mem[bus.rd_addr];
        else           bus.rd_data <= '1;
    end

    function automatic logic win_cell(input logic [3*BL-1:0] lastw, input logic [3*BL-1:0] curw,
                                      input int k, input int c);
        if (c < 0 || c >= 2*BL) return 1'b0;
        if (c < BL) return lastw[k*BL + c];
        return curw[k*BL + c - BL];
    endfunction

    function automatic logic win_life(input logic [3*BL-1:0] lastw, input logic [3*BL-1:0] curw,
                                      input int c);
        int n = 0;
        for (int k = 0; k < 3; k++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(k == 1 && dc == 0)) n += int'(win_cell(lastw, curw, k, c + dc));
        return (n == 3) || (win_cell(lastw, curw, 1, c) && n == 2);
    endfunction

    // Update unit: the last cell of the current block lacks its right neighbour;
    // the previous block's last cell is resolved using the current block's column 0.
    always_comb begin
        bus.now_live = '0;
        for (int j = 0; j < BL; j++)
            bus.now_live[j] = win_life(bus.last_line_status, bus.line_status, BL + j);
        bus.prev_live_single = win_life(bus.last_line_status, bus.line_status, BL - 1);
    end

    function automatic logic bcell(input int r, input int c);
        if (r < 0 || r >= HH || c < 0 || c >= COLS) return 1'b0;
        return board[r][c];
    endfunction

    function automatic logic [3*BL-1:0] exp_win(input int r, input int s);
        logic [3*BL-1:0] w = '0;
        if (s < 0 || s >= WB) return w;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < BL; j++)
                w[k*BL + j] = bcell(r - 1 + k, s*BL + j);
        return w;
    endfunction

    function automatic logic [BL-1:0] exp_next(input int r, input int b);
        logic [BL-1:0] v = '0;
        for (int j = 0; j < BL; j++) v[j] = nxt[r][b*BL + j];
        return v;
    endfunction

    task automatic compute_next();
        for (int r = 0; r < HH; r++)
            for (int c = 0; c < COLS; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0)) n += int'(bcell(r + dr, c + dc));
                nxt[r][c] = (n == 3) || (board[r][c] && n == 2);
            end
    endtask

    task automatic clear_board();
        for (int r = 0; r < HH; r++)
            for (int c = 0; c < COLS; c++) board[r][c] = 1'b0;
    endtask

    task automatic set_cell(input int r, input int c);
        board[r][c] = 1'b1;
    endtask

    task automatic pack_src();
        for (int r = 0; r < HH; r++)
            for (int b = 0; b < WB; b++)
                for (int j = 0; j < BL; j++)
                    src_mem[r*WB + b][j] = board[r][b*BL + j];
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int               o, idx, r, p, s, ph;
    logic             e_busy, e_done, e_rd_en, e_wr_en, in_eval;
    logic [AW-1:0]    e_rd_addr, e_wr_addr;
    logic [BL-1:0]    e_wr_data;
    logic [3*BL-1:0]  e_line, e_last;

    // Per-cycle comparison against the schedule derived from the reference board
    always @(negedge clk) begin
        if (!rst) begin
            e_busy = 0; e_done = 0; e_rd_en = 0; e_wr_en = 0; in_eval = 0;
            e_rd_addr = '0; e_wr_addr = '0; e_wr_data = '0; e_line = '0; e_last = '0;
            o = cyc - base + 1;
            if (active && o >= 1 && o <= N) begin
                e_busy = 1;
                idx = o - 1;
                r = idx / (5*WB + 1);
                p = idx % (5*WB + 1);
                if (p < 5*WB) begin s = p / 5; ph = p % 5; end
                else begin s = WB; ph = 4; end
                if (ph < 3 && (r - 1 + ph) >= 0 && (r - 1 + ph) < HH) begin
                    e_rd_en = 1;
                    e_rd_addr = AW'((r - 1 + ph)*WB + s);
                end
                if (ph == 4) begin
                    in_eval = 1;
                    e_line = exp_win(r, s);
                    e_last = exp_win(r, s - 1);
                    if (s >= 1) begin
                        e_wr_en = 1;
                        e_wr_addr = AW'(r*WB + s - 1);
                        e_wr_data = exp_next(r, s - 1);
                    end
                end
            end else if (active && o == N + 1) begin
                e_done = 1;
            end
            chk("busy", 64'(bus.busy), 64'(e_busy));
            chk("done", 64'(bus.done), 64'(e_done));
            chk("rd_en", 64'(bus.rd_en), 64'(e_rd_en));
            chk("wr_en", 64'(bus.wr_en), 64'(e_wr_en));
            if (e_rd_en) chk("rd_addr", 64'(bus.rd_addr), 64'(e_rd_addr));
            if (e_wr_en) begin
                chk("wr_addr", 64'(bus.wr_addr), 64'(e_wr_addr));
                chk("wr_data", 64'(bus.wr_data), 64'(e_wr_data));
            end
            if (in_eval) begin
                chk("line_status", 64'(bus.line_status), 64'(e_line));
                chk("last_line_status", 64'(bus.last_line_status), 64'(e_last));
            end
            if (bus.wr_en) begin
                wr_count++;
                dst_mem[bus.wr_addr] = bus.wr_data;
            end
            if (bus.busy) busy_count++;
            if (bus.done) begin
                done_count++;
                done_o = o;
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        base = cyc + 1;
        active = 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic prep_gen();
        pack_src();
        compute_next();
        for (int a = 0; a < NW; a++) dst_mem[a] = 4'h5;
        wr_count = 0; done_count = 0; busy_count = 0; done_o = -1;
    endtask

    // One generation; exp_dst holds the expected destination word of address a at nibble a
    task automatic run_gen(input string name, input logic [31:0] exp_dst, input bit extra_start);
        prep_gen();
        do_start();
        if (extra_start) begin
            repeat (9) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            repeat (N + 2 - 10) @(negedge clk);
        end else begin
            repeat (N + 2) @(negedge clk);
        end
        #1;
        chk("write_count", 64'(wr_count), 64'd8);
        chk("done_count", 64'(done_count), 64'd1);
        chk("done_cycle", 64'(done_o), 64'd45);
        chk("busy_cycles", 64'(busy_count), 64'd44);
        for (int a = 0; a < NW; a++)
            chk($sformatf("dst[%0d]", a), 64'(dst_mem[a]), 64'(exp_dst[4*a +: 4]));
        $display("gen %s: %0d writes, done at cycle %0d, dst %h%h%h%h%h%h%h%h", name,
                 wr_count, done_o, dst_mem[7], dst_mem[6], dst_mem[5], dst_mem[4],
                 dst_mem[3], dst_mem[2], dst_mem[1], dst_mem[0]);
    endtask

    task automatic load_blinker();
        clear_board();
        set_cell(1, 2); set_cell(1, 3); set_cell(1, 4);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
        chk({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
        chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
        chk({tag, "_line"}, 64'(bus.line_status), 64'd0);
        chk({tag, "_last_line"}, 64'(bus.last_line_status), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        clear_board();
        pack_src();
        compute_next();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Empty board
        clear_board();
        run_gen("empty", 32'h0000_0000, 1'b0);

        // Blinker across the block boundary: vertical line at column 3
        load_blinker();
        run_gen("blinker", 32'h0008_0808, 1'b0);

        // Bottom-right 2x2 block stays put
        clear_board();
        set_cell(2, 6); set_cell(2, 7); set_cell(3, 6); set_cell(3, 7);
        run_gen("still_life", 32'hC0C0_0000, 1'b0);

        // Isolated corner cells all die
        clear_board();
        set_cell(0, 0); set_cell(0, 7); set_cell(3, 0); set_cell(3, 7);
        run_gen("corners", 32'h0000_0000, 1'b0);

        // Reset in the middle of a generation, then restart
        load_blinker();
        prep_gen();
        do_start();
        repeat (19) @(negedge clk);
        #1;
        rst = 1'b1;
        active = 0;
        #1;
        check_idle_outputs("mid_reset");
        $display("gen mid_reset: reset applied at cycle offset 20");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        load_blinker();
        run_gen("blinker_after_reset", 32'h0008_0808, 1'b0);

        // Second start while busy is ignored
        load_blinker();
        run_gen("double_start", 32'h0008_0808, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
